// File: rtl/id_ex_alu_issue_pkg.sv
// Shared ALU control encodings, ALUOp values and R-type funct codes
// for the ID/EX issue stage.
package id_ex_alu_issue_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100,
        ALU_SLL = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_RTYPE = 2'b10,
        OP_OR    = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

endpackage

// File: rtl/id_ex_alu_issue_if.sv
// EX-stage issue bundle: ALU operands/control plus the registered EX
// bookkeeping. The issue stage drives it (master), the EX stage reads it (slave).
interface id_ex_alu_issue_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       alu_control;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] ex_store_data;
    logic             ex_valid;
    logic [4:0]       ex_dest;
    logic             ex_reg_write;
    logic             ex_ovf_en;
    logic             ex_illegal;

    modport master (
        output alu_control, alu_shamt, alu_a, alu_b, ex_store_data,
               ex_valid, ex_dest, ex_reg_write, ex_ovf_en, ex_illegal
    );

    modport slave (
        input alu_control, alu_shamt, alu_a, alu_b, ex_store_data,
              ex_valid, ex_dest, ex_reg_write, ex_ovf_en, ex_illegal
    );
endinterface

// File: rtl/id_ex_alu_issue_alu_ctrl_decode.sv
// Combinational ALUOp/funct decode into ALU control code, shift amount,
// overflow-trap enable and illegal-funct flag.
module alu_ctrl_decode
    import id_ex_alu_issue_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic [4:0] shamt,
    output alu_ctrl_e  ctrl,
    output logic [4:0] alu_shamt,
    output logic       ovf_en,
    output logic       illegal
);

    always_comb begin
        ctrl      = ALU_ADD;
        alu_shamt = '0;
        ovf_en    = 1'b0;
        illegal   = 1'b0;
        case (alu_op_e'(alu_op))
            OP_ADD: ctrl = ALU_ADD;
            OP_SUB: ctrl = ALU_SUB;
            OP_OR:  ctrl = ALU_OR;
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:  begin ctrl = ALU_ADD; ovf_en = 1'b1; end
                    FUNCT_ADDU: ctrl = ALU_ADD;
                    FUNCT_SUB:  begin ctrl = ALU_SUB; ovf_en = 1'b1; end
                    FUNCT_SUBU: ctrl = ALU_SUB;
                    FUNCT_AND:  ctrl = ALU_AND;
                    FUNCT_OR:   ctrl = ALU_OR;
                    FUNCT_NOR:  ctrl = ALU_NOR;
                    FUNCT_SLT:  ctrl = ALU_SLT;
                    FUNCT_SLL:  begin ctrl = ALU_SLL; alu_shamt = shamt; end
                    default:    begin ctrl = ALU_AND; illegal = 1'b1; end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register with stall/flush, ALU control decode and
// EX/MEM, MEM/WB operand forwarding onto the ALU issue bundle.
module id_ex_alu_issue
    import id_ex_alu_issue_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [1:0]       id_alu_op,
    input  logic [5:0]       id_funct,
    input  logic [4:0]       id_shamt,
    input  logic             id_alu_src,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_reg_write,
    input  logic             exmem_reg_write,
    input  logic [4:0]       exmem_dest,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [4:0]       memwb_dest,
    input  logic [WIDTH-1:0] memwb_result,
    id_ex_alu_issue_if.master alu
);

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        alu_ctrl_e        ctrl;
        logic [4:0]       shamt;
        logic             ovf_en;
        logic             illegal;
        logic             alu_src;
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [WIDTH-1:0] imm;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       dest;
    } idex_t;

    localparam idex_t BUBBLE = '{ctrl: ALU_ADD, default: '0};

    alu_ctrl_e        dec_ctrl;
    logic [4:0]       dec_shamt;
    logic             dec_ovf_en;
    logic             dec_illegal;
    idex_t            q;
    idex_t            d;
    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    alu_ctrl_decode u_decode (
        .alu_op    (id_alu_op),
        .funct     (id_funct),
        .shamt     (id_shamt),
        .ctrl      (dec_ctrl),
        .alu_shamt (dec_shamt),
        .ovf_en    (dec_ovf_en),
        .illegal   (dec_illegal)
    );

    always_comb begin
        d = BUBBLE;
        if (id_valid && !flush) begin
            d.valid     = 1'b1;
            d.reg_write = id_reg_write & ~dec_illegal;
            d.ctrl      = dec_ctrl;
            d.shamt     = dec_shamt;
            d.ovf_en    = dec_ovf_en;
            d.illegal   = dec_illegal;
            d.alu_src   = id_alu_src;
            d.rs_data   = id_rs_data;
            d.rt_data   = id_rt_data;
            d.imm       = id_imm;
            d.rs        = id_rs;
            d.rt        = id_rt;
            d.dest      = id_dest;
        end
    end

    // Flush overrides stall: the register is enabled whenever flush is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (flush || !stall) begin
            q <= d;
        end
    end

    // Forwarding watches the live EX/MEM and MEM/WB ports, so it tracks them during stalls.
    always_comb begin
        fwd_rs = q.rs_data;
        fwd_rt = q.rt_data;
        if (q.rs != '0) begin
            if (exmem_reg_write && exmem_dest == q.rs) fwd_rs = exmem_result;
            else if (memwb_reg_write && memwb_dest == q.rs) fwd_rs = memwb_result;
        end
        if (q.rt != '0) begin
            if (exmem_reg_write && exmem_dest == q.rt) fwd_rt = exmem_result;
            else if (memwb_reg_write && memwb_dest == q.rt) fwd_rt = memwb_result;
        end
    end

    assign alu.alu_control   = q.ctrl;
    assign alu.alu_shamt     = q.shamt;
    assign alu.alu_a         = fwd_rs;
    assign alu.alu_b         = q.alu_src ? q.imm : fwd_rt;
    assign alu.ex_store_data = fwd_rt;
    assign alu.ex_valid      = q.valid;
    assign alu.ex_dest       = q.dest;
    assign alu.ex_reg_write  = q.reg_write;
    assign alu.ex_ovf_en     = q.ovf_en;
    assign alu.ex_illegal    = q.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: stimulus pushes hand-computed EX
// expectations tagged with a cycle; a negedge monitor pops and compares.
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, id_valid, id_alu_src, id_reg_write;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic [4:0]  id_shamt, id_rs, id_rt, id_dest;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_dest, memwb_dest;
    logic [31:0] exmem_result, memwb_result;

    id_ex_alu_issue_if #(.WIDTH(32)) alu_bus ();

    id_ex_alu_issue #(.WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_alu_op       (id_alu_op),
        .id_funct        (id_funct),
        .id_shamt        (id_shamt),
        .id_alu_src      (id_alu_src),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_dest         (id_dest),
        .id_reg_write    (id_reg_write),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .alu             (alu_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic        valid;
        logic        rw;
        logic [3:0]  ctrl;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store;
        logic        ovf;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("cycle_tag", cyc, e.cyc);
            chk("ex_valid",      32'(alu_bus.ex_valid),     32'(e.valid));
            chk("ex_reg_write",  32'(alu_bus.ex_reg_write), 32'(e.rw));
            chk("alu_control",   32'(alu_bus.alu_control),  32'(e.ctrl));
            chk("alu_shamt",     32'(alu_bus.alu_shamt),    32'(e.shamt));
            chk("ex_dest",       32'(alu_bus.ex_dest),      32'(e.dest));
            chk("alu_a",         alu_bus.alu_a,             e.a);
            chk("alu_b",         alu_bus.alu_b,             e.b);
            chk("ex_store_data", alu_bus.ex_store_data,     e.store);
            chk("ex_ovf_en",     32'(alu_bus.ex_ovf_en),    32'(e.ovf));
            chk("ex_illegal",    32'(alu_bus.ex_illegal),   32'(e.ill));
        end
    end

    function automatic exp_t mk(input logic v, input logic rw, input logic [3:0] ctrl,
                                input logic [4:0] sh, input logic [4:0] dst,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] st, input logic ovf, input logic ill);
        exp_t e;
        e.cyc = 0; e.valid = v; e.rw = rw; e.ctrl = ctrl; e.shamt = sh; e.dest = dst;
        e.a = a; e.b = b; e.store = st; e.ovf = ovf; e.ill = ill;
        return e;
    endfunction

    task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] fn,
                          input logic [4:0] sh, input logic src, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] dst, input logic rw);
        id_valid = v; id_alu_op = op; id_funct = fn; id_shamt = sh; id_alu_src = src;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_rs = rs; id_rt = rt;
        id_dest = dst; id_reg_write = rw;
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] ed, input logic [31:0] er,
                           input logic mrw, input logic [4:0] md, input logic [31:0] mr);
        exmem_reg_write = erw; exmem_dest = ed; exmem_result = er;
        memwb_reg_write = mrw; memwb_dest = md; memwb_result = mr;
    endtask

    // Clock the prepared inputs in and queue what EX must show this cycle.
    task automatic edge_expect(input exp_t e);
        @(posedge clk);
        #1;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic next_drive();
        @(negedge clk);
        #1;
    endtask

    logic [5:0] fn_tab [7] = '{6'b100100, 6'b100101, 6'b100111, 6'b101010,
                               6'b100000, 6'b100001, 6'b100011};
    logic [3:0] ct_tab [7] = '{4'b0000, 4'b0001, 4'b1100, 4'b0111,
                               4'b0010, 4'b0010, 4'b0110};
    logic       ov_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    exp_t bubble;

    initial begin
        bubble = mk(0, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(0, 2'b00, 6'd0, 5'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        set_fwd(0, 5'd0, 0, 0, 5'd0, 0);
        edge_expect(bubble);
        next_drive();
        rst = 1'b0;

        // R-type SUB
        set_id(1, 2'b10, 6'b100010, 5'd0, 0, 32'd7, 32'd3, 0, 5'd5, 5'd6, 5'd9, 1);
        edge_expect(mk(1, 1, 4'b0110, 0, 5'd9, 32'd7, 32'd3, 32'd3, 1, 0));

        // SLL with shamt 4
        next_drive();
        set_id(1, 2'b10, 6'b000000, 5'd4, 0, 32'h55, 32'd1, 0, 5'd0, 5'd6, 5'd10, 1);
        edge_expect(mk(1, 1, 4'b1111, 5'd4, 5'd10, 32'h55, 32'd1, 32'd1, 0, 0));

        // Illegal funct
        next_drive();
        set_id(1, 2'b10, 6'b111111, 5'd4, 0, 32'h55, 32'd1, 0, 5'd0, 5'd6, 5'd10, 1);
        edge_expect(mk(1, 0, 4'b0000, 0, 5'd10, 32'h55, 32'd1, 32'd1, 0, 1));

        // Forwarding: EX/MEM wins over MEM/WB
        next_drive();
        set_id(1, 2'b00, 6'd0, 5'd0, 1, 32'h11, 32'h22, 32'h10, 5'd8, 5'd3, 5'd12, 1);
        set_fwd(1, 5'd8, 32'hAA, 1, 5'd8, 32'hBB);
        edge_expect(mk(1, 1, 4'b0010, 0, 5'd12, 32'hAA, 32'h10, 32'h22, 0, 0));

        // Stall three cycles with changing ID and forwarding sources
        next_drive();
        stall = 1'b1;
        set_id(1, 2'b10, 6'b100000, 5'd3, 0, 32'h99, 32'h98, 32'h97, 5'd7, 5'd7, 5'd7, 0);
        set_fwd(1, 5'd0, 32'hAA, 1, 5'd8, 32'hBB);
        edge_expect(mk(1, 1, 4'b0010, 0, 5'd12, 32'hBB, 32'h10, 32'h22, 0, 0));
        next_drive();
        set_id(1, 2'b01, 6'b000000, 5'd1, 0, 32'h88, 32'h87, 32'h86, 5'd6, 5'd6, 5'd6, 1);
        set_fwd(0, 5'd8, 32'hAA, 0, 5'd8, 32'hBB);
        edge_expect(mk(1, 1, 4'b0010, 0, 5'd12, 32'h11, 32'h10, 32'h22, 0, 0));
        next_drive();
        set_id(0, 2'b11, 6'b111111, 5'd2, 1, 32'h77, 32'h76, 32'h75, 5'd5, 5'd5, 5'd5, 1);
        set_fwd(1, 5'd3, 32'hCC, 0, 5'd0, 0);
        edge_expect(mk(1, 1, 4'b0010, 0, 5'd12, 32'h11, 32'h10, 32'hCC, 0, 0));

        // Register 0 never forwarded
        next_drive();
        stall = 1'b0;
        set_id(1, 2'b01, 6'd0, 5'd0, 0, 32'h33, 32'h44, 0, 5'd0, 5'd0, 5'd13, 1);
        set_fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
        edge_expect(mk(1, 1, 4'b0110, 0, 5'd13, 32'h33, 32'h44, 32'h44, 0, 0));

        // ORI; store data forwarded from MEM/WB
        next_drive();
        set_id(1, 2'b11, 6'd0, 5'd0, 1, 32'd9, 32'd1, 32'hF0, 5'd2, 5'd4, 5'd4, 1);
        set_fwd(0, 5'd4, 32'hAA, 1, 5'd4, 32'h77);
        edge_expect(mk(1, 1, 4'b0001, 0, 5'd4, 32'd9, 32'hF0, 32'h77, 0, 0));

        // Flush together with stall loads a bubble
        next_drive();
        set_fwd(0, 5'd0, 0, 0, 5'd0, 0);
        flush = 1'b1; stall = 1'b1;
        edge_expect(bubble);
        next_drive();
        flush = 1'b0; stall = 1'b0;

        // Remaining R-type decodes
        for (int i = 0; i < 7; i++) begin
            set_id(1, 2'b10, fn_tab[i], 5'd9, 0, 32'(i + 1), 32'h100, 0, 5'd1, 5'd2, 5'd3, 1);
            edge_expect(mk(1, 1, ct_tab[i], 0, 5'd3, 32'(i + 1), 32'h100, 32'h100, ov_tab[i], 0));
            next_drive();
        end

        // id_valid low loads a bubble
        set_id(0, 2'b10, 6'b100000, 5'd0, 0, 32'h5, 32'h6, 0, 5'd1, 5'd2, 5'd3, 1);
        edge_expect(bubble);

        // Asynchronous reset while a valid instruction sits in EX
        next_drive();
        set_id(1, 2'b10, 6'b100000, 5'd0, 0, 32'h5, 32'h6, 0, 5'd1, 5'd2, 5'd3, 1);
        edge_expect(mk(1, 1, 4'b0010, 0, 5'd3, 32'h5, 32'h6, 32'h6, 1, 0));
        next_drive();
        stall = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        bubble.cyc = cyc;
        sb.push_back(bubble);
        next_drive();
        rst = 1'b0; stall = 1'b0;

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

endmodule
